// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// The grant encoding doubles as the externally visible FSM state.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } wb_arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall counter: counts cycles while run is high and flags expiry when the
// count reaches TIMEOUT_CYCLES. Only instantiated for TIMEOUT_CYCLES > 0.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // Saturates at LIMIT so a missed clear can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = run & (r_count == LIMIT);

endmodule

// File: rtl/wishbone_arbiter_2to1.sv
// Two-master Wishbone classic arbiter: round-robin grant, locked for the
// owner's cyc, with a watchdog that aborts stalled strobes.
module wishbone_arbiter_2to1
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  // Handshake: a transfer is offered while cyc & stb are high and completes
  // in the cycle the slave raises ack; only the granted master sees that ack.
  wb_arb_state_t r_state;
  wb_arb_state_t w_next_state;
  logic          r_last;
  logic          w_req0;
  logic          w_req1;
  logic          w_wd_run;
  logic          w_wd_clear;
  logic          w_wd_expired;
  logic          w_timeout;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

  assign w_wd_run   = ((r_state == GNT0) & w_req0 | (r_state == GNT1) & w_req1) & ~s_ack_i;
  assign w_wd_clear = ~w_wd_run | (w_next_state != r_state);
  // Ack wins over expiry because an acked cycle never counts as running.
  assign w_timeout  = w_wd_expired;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (w_wd_run),
        .clear  (w_wd_clear),
        .expired(w_wd_expired)
      );
    end else begin : g_no_wdog
      assign w_wd_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == GNT0) r_last <= 1'b0;
      else if (w_next_state == GNT1) r_last <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next_state = r_last ? GNT0 : GNT1;
        else if (w_req0)      w_next_state = GNT0;
        else if (w_req1)      w_next_state = GNT1;
      end
      GNT0: begin
        if (w_timeout)      w_next_state = IDLE;
        else if (!m0_cyc_i) w_next_state = w_req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        if (w_timeout)      w_next_state = IDLE;
        else if (!m1_cyc_i) w_next_state = w_req0 ? GNT0 : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    grant_o   = GRANT_NONE;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_err_o  = 1'b0;
    timeout_o = 1'b0;
    case (r_state)
      GNT0: begin
        grant_o   = GRANT_M0;
        s_cyc_o   = m0_cyc_i & ~w_timeout;
        s_stb_o   = m0_stb_i & ~w_timeout;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_sel_o   = m0_sel_i;
        m0_ack_o  = s_ack_i;
        m0_err_o  = w_timeout;
        timeout_o = w_timeout;
      end
      GNT1: begin
        grant_o   = GRANT_M1;
        s_cyc_o   = m1_cyc_i & ~w_timeout;
        s_stb_o   = m1_stb_i & ~w_timeout;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_sel_o   = m1_sel_i;
        m1_ack_o  = s_ack_i;
        m1_err_o  = w_timeout;
        timeout_o = w_timeout;
      end
      default: ;
    endcase
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_wishbone_arbiter_2to1.sv
// Self-checking bench for wishbone_arbiter_2to1 with a 4-cycle watchdog;
// acked read data is tracked through an expected queue.
module tb_wishbone_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  wishbone_arbiter_2to1 #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_addr_i = addr; m0_data_i = data; m0_sel_i = 4'hF;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_addr_i = addr; m1_data_i = data; m1_sel_i = 4'hF;
    end
  endtask

  task automatic slave_ack(input int m);
    logic [32:0] e;
    s_data_i = $urandom;
    s_ack_i  = 1'b1;
    e = {(m == 1), s_data_i};
    exp_q.push_back(e);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_grant"}, grant_o, 2'b00);
    check({tag, "_s_cyc"}, s_cyc_o, 1'b0);
    check({tag, "_s_stb"}, s_stb_o, 1'b0);
    check({tag, "_s_addr"}, s_addr_o, 32'h0);
  endtask

  // scoreboard: every master ack must match the head of the expected queue
  always @(negedge clk) begin
    logic [32:0] e;
    if (m0_ack_o === 1'b1 || m1_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", {m1_ack_o, m0_ack_o}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("ack_master", {m1_ack_o, m0_ack_o}, e[32] ? 2'b10 : 2'b01);
        check("ack_data", e[32] ? m1_data_o : m0_data_o, e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    s_ack_i = 1'b0;
    s_data_i = '0;
    drive_m(0, 0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0, 0);
    step(); step();
    settle();
    check_idle_bus("reset");
    check("reset_timeout", timeout_o, 1'b0);
    step();
    rst_n = 1'b1;

    // single master read on m1, acked on second strobe cycle
    drive_m(1, 1, 1, 0, 32'h0000_0100, 0);
    settle();
    check("t1_pre_grant", grant_o, 2'b00);
    step();
    settle();
    check("t1_grant", grant_o, 2'b10);
    check("t1_s_stb", s_stb_o, 1'b1);
    check("t1_s_addr", s_addr_o, 32'h100);
    check("t1_s_we", s_we_o, 1'b0);
    step();
    slave_ack(1);
    settle();
    check("t1_m0_ack", m0_ack_o, 1'b0);
    step();
    s_ack_i = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0);
    step();
    settle();
    check_idle_bus("t1_end");

    // contention from reset pointer: m0 first, then zero-cycle handover
    drive_m(0, 1, 1, 0, 32'h0000_0200, 0);
    drive_m(1, 1, 1, 1, 32'h0000_0300, 32'hCAFE_0001);
    step();
    settle();
    check("t2_first_grant", grant_o, 2'b01);
    check("t2_s_addr_m0", s_addr_o, 32'h200);
    step();
    slave_ack(0);
    step();
    s_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0);
    settle();
    check("t2_no_m1_cyc_path", s_cyc_o, 1'b0);
    step();
    settle();
    check("t2_handover", grant_o, 2'b10);
    check("t2_s_data_m1", s_data_o, 32'hCAFE_0001);
    slave_ack(1);
    step();
    s_ack_i = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0);
    step();
    settle();
    check("t2_idle", grant_o, 2'b00);
    drive_m(0, 1, 1, 0, 32'h0000_0204, 0);
    drive_m(1, 1, 1, 0, 32'h0000_0304, 0);
    step();
    settle();
    check("t2_second_contention", grant_o, 2'b01);

    // bus lock: m0 keeps cyc over three acked transfers while m1 waits
    for (int i = 0; i < 3; i++) begin
      m0_addr_i = 32'h0000_0400 + 32'(i * 4);
      step();
      slave_ack(0);
      settle();
      check("t3_lock_grant", grant_o, 2'b01);
      check("t3_m1_ack", m1_ack_o, 1'b0);
      step();
      s_ack_i = 1'b0;
      settle();
      check("t3_lock_hold", grant_o, 2'b01);
    end
    drive_m(0, 0, 0, 0, 0, 0);
    step();
    settle();
    check("t3_release", grant_o, 2'b10);
    drive_m(1, 0, 0, 0, 0, 0);
    step();
    step();

    // watchdog: m1 write never acked, err exactly 4 cycles after stb rises
    drive_m(1, 1, 1, 1, 32'h0000_0500, 32'h1234_5678);
    step();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_no_err_yet", {m1_err_o, timeout_o}, 2'b00);
      check("t4_s_stb", s_stb_o, 1'b1);
      step();
    end
    settle();
    check("t4_m1_err", m1_err_o, 1'b1);
    check("t4_timeout", timeout_o, 1'b1);
    check("t4_m0_err", m0_err_o, 1'b0);
    check("t4_s_cyc_forced", s_cyc_o, 1'b0);
    check("t4_s_stb_forced", s_stb_o, 1'b0);
    step();
    drive_m(1, 0, 0, 0, 0, 0);
    settle();
    check("t4_after_err_idle", grant_o, 2'b00);
    check("t4_err_one_cycle", m1_err_o, 1'b0);

    // same-cycle ack and expiry: ack wins
    drive_m(1, 1, 1, 0, 32'h0000_0600, 0);
    step();
    for (int i = 0; i < 4; i++) step();
    slave_ack(1);
    settle();
    check("t4b_no_err", {m1_err_o, timeout_o}, 2'b00);
    check("t4b_s_stb", s_stb_o, 1'b1);
    step();
    s_ack_i = 1'b0;
    drive_m(1, 0, 0, 0, 0, 0);
    step();

    // reset in the middle of a GNT0 transaction
    drive_m(0, 1, 1, 0, 32'h0000_0700, 0);
    step();
    settle();
    check("t5_gnt0", grant_o, 2'b01);
    step();
    rst_n = 1'b0;
    step();
    s_ack_i = 1'b1;
    settle();
    check_idle_bus("t5_in_reset");
    check("t5_s_data", s_data_o, 32'h0);
    check("t5_s_sel", s_sel_o, 4'h0);
    check("t5_acks", {m1_ack_o, m0_ack_o}, 2'b00);
    check("t5_errs", {m1_err_o, m0_err_o, timeout_o}, 3'b000);
    step();
    rst_n = 1'b1;
    s_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 0, 0);
    step();
    drive_m(0, 1, 1, 0, 32'h0000_0800, 0);
    drive_m(1, 1, 1, 0, 32'h0000_0900, 0);
    step();
    settle();
    check("t5_post_reset_contention", grant_o, 2'b01);
    step();
    drive_m(0, 0, 0, 0, 0, 0);
    drive_m(1, 0, 0, 0, 0, 0);
    step();
    step();

    // final report
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
